// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: core load/store (port 0) and loader/debug (port 1)
// share one single-cycle RAM. Each access takes IDLE -> ISSUE -> DONE, so at most
// one access is accepted every three cycles.
// Optional feature: define DMEM_ARB_RR_EN for round-robin arbitration on contention;
// otherwise port 0 has fixed priority and no pointer register exists.
module dmem_arbiter (
    input  logic        clk,
    input  logic        rst,
    // port 0: core load/store
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [2:0]  m0_rwtype,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    // port 1: loader/debug
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [2:0]  m1_rwtype,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    // memory side
    output logic        W_en,
    output logic        R_en,
    output logic [31:0] ram_addr,
    output logic [2:0]  RW_type,
    output logic [31:0] WD,
    input  logic [31:0] RD
);

    typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

    state_e      state_q, state_d;
    logic        win_q;       // id of the port being served
    logic        win_sel;     // id of the port that wins this IDLE cycle
    logic        accept;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [2:0]  lat_rwtype;
    logic        aligned;
    logic [31:0] rdata0_q, rdata1_q;

`ifdef DMEM_ARB_RR_EN
    logic last_q;             // port served most recently

    // Round-robin pointer: reset means "port 1 served last" so port 0 wins first
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (accept) begin
            last_q <= win_sel;
        end
    end

    // Contention goes to the port not served most recently
    always_comb begin
        win_sel = (m0_req && m1_req) ? ~last_q : m1_req;
    end
`else
    // Fixed priority: port 0 wins whenever it requests
    always_comb begin
        win_sel = ~m0_req;
    end
`endif

    // Accept a command only from IDLE; requests are ignored in ISSUE and DONE
    always_comb begin
        accept = (state_q == StIdle) && (m0_req || m1_req);
    end

    // Size/alignment check on the latched command; size 11 is never legal
    always_comb begin
        unique case (lat_rwtype[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~lat_addr[0];
            2'b10:   aligned = (lat_addr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StIssue;
            StIssue: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Command latch and winner id, captured at the accepting edge
    always_ff @(posedge clk) begin
        if (rst) begin
            win_q      <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_rwtype <= '0;
        end else if (accept) begin
            win_q      <= win_sel;
            lat_we     <= win_sel ? m1_we     : m0_we;
            lat_addr   <= win_sel ? m1_addr   : m0_addr;
            lat_wdata  <= win_sel ? m1_wdata  : m0_wdata;
            lat_rwtype <= win_sel ? m1_rwtype : m0_rwtype;
        end
    end

    // Per-port load data, captured from RD at the end of an aligned ISSUE load
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else if (state_q == StIssue && !lat_we && aligned) begin
            if (win_q) begin
                rdata1_q <= RD;
            end else begin
                rdata0_q <= RD;
            end
        end
    end

    // Outputs decoded from state; memory address/type/data come straight from the
    // latch so they hold their values outside ISSUE
    always_comb begin
        m0_gnt    = 1'b0;
        m1_gnt    = 1'b0;
        m0_rvalid = 1'b0;
        m1_rvalid = 1'b0;
        m0_err    = 1'b0;
        m1_err    = 1'b0;
        W_en      = 1'b0;
        R_en      = 1'b0;
        ram_addr  = lat_addr;
        RW_type   = lat_rwtype;
        WD        = lat_wdata;
        m0_rdata  = rdata0_q;
        m1_rdata  = rdata1_q;
        unique case (state_q)
            StIssue: begin
                m0_gnt = ~win_q;
                m1_gnt = win_q;
                W_en   = lat_we && aligned;
                R_en   = !lat_we && aligned;
            end
            StDone: begin
                m0_rvalid = ~win_q && !lat_we && aligned;
                m1_rvalid = win_q && !lat_we && aligned;
                m0_err    = ~win_q && !aligned;
                m1_err    = win_q && !aligned;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: drivers push expected grants/responses computed
// from a byte-array memory model; a negedge monitor pops and compares.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ram_init = 1'b1;
    logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
    logic [2:0]  m0_rwtype = 0, m1_rwtype = 0;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        W_en, R_en;
    logic [31:0] ram_addr, WD, RD;
    logic [2:0]  RW_type;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rwtype(m0_rwtype), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rwtype(m1_rwtype), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .m1_rdata(m1_rdata), .m1_err(m1_err),
        .W_en(W_en), .R_en(R_en), .ram_addr(ram_addr), .RW_type(RW_type),
        .WD(WD), .RD(RD)
    );

    always #5 clk = ~clk;

    // Environment RAM: 256 bytes, little-endian, combinational read
    logic [7:0] ram [256];
    logic [7:0] ra;
    assign ra = ram_addr[7:0];
    assign RD = {ram[ra + 8'd3], ram[ra + 8'd2], ram[ra + 8'd1], ram[ra]};

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'h5a;
        end else if (W_en) begin
            ram[ra] <= WD[7:0];
            if (RW_type[1:0] != 2'b00) ram[ra + 8'd1] <= WD[15:8];
            if (RW_type[1:0] == 2'b10) begin
                ram[ra + 8'd2] <= WD[23:16];
                ram[ra + 8'd3] <= WD[31:24];
            end
        end
    end

    // Reference model state
    typedef struct {
        int          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  rwt;
        bit          mis;
    } cmd_t;
    typedef struct {
        int          port;
        bit          err;
        logic [31:0] data;
    } resp_t;

    cmd_t        gq[$];
    resp_t       rq[$];
    logic [7:0]  sh [256];
    logic [31:0] last_rd [2];
    int          last_srv;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit misaligned(input logic [31:0] a, input logic [2:0] t);
        case (t[1:0])
            2'b00:   return 1'b0;
            2'b01:   return a[0];
            2'b10:   return a[1:0] != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    // Apply one accepted command to the model and queue its expected effects
    task automatic predict(input cmd_t c);
        logic [7:0] a;
        resp_t r;
        a = c.addr[7:0];
        gq.push_back(c);
        last_srv = c.port;
        r.port = c.port;
        r.err  = c.mis;
        r.data = {sh[a + 8'd3], sh[a + 8'd2], sh[a + 8'd1], sh[a]};
        if (c.mis || !c.we) rq.push_back(r);
        if (c.we && !c.mis) begin
            sh[a] = c.wdata[7:0];
            if (c.rwt[1:0] >= 2'b01) sh[a + 8'd1] = c.wdata[15:8];
            if (c.rwt[1:0] == 2'b10) begin
                sh[a + 8'd2] = c.wdata[23:16];
                sh[a + 8'd3] = c.wdata[31:24];
            end
        end
    endtask

    task automatic set_port(input int p, input bit we, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [2:0] t);
        if (p == 0) begin
            m0_we = we; m0_addr = addr; m0_wdata = wd; m0_rwtype = t;
        end else begin
            m1_we = we; m1_addr = addr; m1_wdata = wd; m1_rwtype = t;
        end
    endtask

    function automatic cmd_t mk(input int p, input bit we, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [2:0] t);
        cmd_t c;
        c.port = p; c.we = we; c.addr = addr; c.wdata = wd; c.rwt = t;
        c.mis = misaligned(addr, t);
        return c;
    endfunction

    // Monitor: compare every grant and every response against the queues
    always @(negedge clk) begin
        cmd_t        c;
        resp_t       r;
        logic        rv, er;
        logic [31:0] rd;
        if (!rst) begin
            chk("gnt_onehot", 32'(m0_gnt & m1_gnt), 32'd0);
            if (m0_gnt || m1_gnt) begin
                if (gq.size() == 0) begin
                    chk("gnt_unexpected", 32'd1, 32'd0);
                end else begin
                    c = gq.pop_front();
                    chk("gnt_port", 32'(m1_gnt), 32'(c.port));
                    chk("w_en", 32'(W_en), 32'(c.we && !c.mis));
                    chk("r_en", 32'(R_en), 32'(!c.we && !c.mis));
                    if (!c.mis) begin
                        chk("ram_addr", ram_addr, c.addr);
                        chk("rw_type", 32'(RW_type), 32'(c.rwt));
                        if (c.we) chk("wd", WD, c.wdata);
                    end
                end
            end else begin
                chk("mem_idle", 32'({W_en, R_en}), 32'd0);
            end
            for (int p = 0; p < 2; p++) begin
                rv = (p == 0) ? m0_rvalid : m1_rvalid;
                er = (p == 0) ? m0_err : m1_err;
                rd = (p == 0) ? m0_rdata : m1_rdata;
                if (rv || er) begin
                    if (rq.size() == 0) begin
                        chk("resp_unexpected", 32'd1, 32'd0);
                    end else begin
                        r = rq.pop_front();
                        chk("resp_port", 32'(p), 32'(r.port));
                        chk("resp_kind", 32'({er, rv}), 32'({r.err, !r.err}));
                        if (rv) chk("rdata", rd, r.data);
                    end
                end
                if (rv) last_rd[p] = rd;
                else chk("rdata_hold", rd, last_rd[p]);
            end
        end
    end

    // One request on one port; checks gnt latency and the DONE-cycle pulse
    task automatic txn(input int p, input bit we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [2:0] t);
        cmd_t c;
        int   lat;
        c = mk(p, we, addr, wd, t);
        set_port(p, we, addr, wd, t);
        predict(c);
        if (p == 0) m0_req = 1'b1; else m1_req = 1'b1;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if ((p == 0 && m0_gnt) || (p == 1 && m1_gnt)) begin
                lat = i;
                break;
            end
        end
        chk("gnt_latency", 32'(lat), 32'd2);
        @(posedge clk); #1;
        m0_req = 1'b0; m1_req = 1'b0;
        @(negedge clk);
        if (p == 0) chk("done_pulse", 32'({m0_err, m0_rvalid}), 32'({c.mis, !c.mis && !we}));
        else        chk("done_pulse", 32'({m1_err, m1_rvalid}), 32'({c.mis, !c.mis && !we}));
        @(posedge clk); #1;
    endtask

    // Both ports request continuously until n grants have been seen
    task automatic contend(input int n);
        cmd_t c0, c1;
        int   w, cnt;
        c0 = mk(0, 1'b0, 32'h40, 32'h0, 3'b010);
        c1 = mk(1, 1'b0, 32'h80, 32'h0, 3'b010);
        set_port(0, c0.we, c0.addr, c0.wdata, c0.rwt);
        set_port(1, c1.we, c1.addr, c1.wdata, c1.rwt);
        for (int i = 0; i < n; i++) begin
`ifdef DMEM_ARB_RR_EN
            w = 1 - last_srv;
`else
            w = 0;
`endif
            predict((w == 0) ? c0 : c1);
        end
        m0_req = 1'b1; m1_req = 1'b1;
        cnt = 0;
        for (int i = 0; i < 60 && cnt < n; i++) begin
            @(negedge clk);
            if (m0_gnt || m1_gnt) cnt++;
        end
        chk("contend_grants", 32'(cnt), 32'(n));
        @(posedge clk); #1;
        m0_req = 1'b0; m1_req = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_gnt"}, 32'({m0_gnt, m1_gnt}), 32'd0);
        chk({tag, "_rvalid"}, 32'({m0_rvalid, m1_rvalid}), 32'd0);
        chk({tag, "_err"}, 32'({m0_err, m1_err}), 32'd0);
        chk({tag, "_en"}, 32'({W_en, R_en}), 32'd0);
        chk({tag, "_ram_addr"}, ram_addr, 32'd0);
        chk({tag, "_rw_type"}, 32'(RW_type), 32'd0);
        chk({tag, "_wd"}, WD, 32'd0);
        chk({tag, "_m0_rdata"}, m0_rdata, 32'd0);
        chk({tag, "_m1_rdata"}, m1_rdata, 32'd0);
    endtask

    initial begin
        cmd_t c;
        int   got;
        for (int i = 0; i < 256; i++) sh[i] = 8'(i) ^ 8'h5a;
        last_rd[0] = '0; last_rd[1] = '0;
        last_srv = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0; ram_init = 1'b0;

        // Preload via port 1, then single load, store and read-back
        txn(1, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010);
        txn(0, 1'b0, 32'h10, 32'h0, 3'b010);
        txn(1, 1'b1, 32'h20, 32'h12345678, 3'b010);
        txn(0, 1'b0, 32'h20, 32'h0, 3'b010);
        // Misaligned halfword, then byte load at the same address
        txn(0, 1'b0, 32'h13, 32'h0, 3'b001);
        txn(0, 1'b0, 32'h13, 32'h0, 3'b000);
        txn(1, 1'b1, 32'h22, 32'hCAFEF00D, 3'b011);

        // Random single-port traffic
        for (int i = 0; i < 40; i++) begin
            txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                {$urandom_range(0, 255), 8'($urandom)}, $urandom,
                3'($urandom_range(0, 7)));
        end

        contend(4);

        // Reset during ISSUE of a port-1 load aborts it
        c = mk(1, 1'b0, 32'h10, 32'h0, 3'b010);
        set_port(1, c.we, c.addr, c.wdata, c.rwt);
        gq.push_back(c);
        m1_req = 1'b1;
        got = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m1_gnt) begin
                got = 1;
                break;
            end
        end
        chk("abort_gnt_seen", 32'(got), 32'd1);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        m1_req = 1'b0;
        last_rd[0] = '0; last_rd[1] = '0;
        last_srv = 1;
        @(negedge clk);
        check_zero("abort");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        contend(1);
        txn(0, 1'b0, 32'h40, 32'h0, 3'b010);

        repeat (3) @(posedge clk);
        chk("gnt_queue_empty", 32'(gq.size()), 32'd0);
        chk("resp_queue_empty", 32'(rq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk input 1 (rising-edge clock); rst input 1 (synchronous, active-high reset).
REQ-002 SHALL provide, for port x in {0 = core load/store, 1 = loader/debug}: mx_req input 1 (access request).
REQ-003 mx_we input 1 (1 = store, 0 = load); mx_addr input 32 (byte address); mx_wdata input 32 (store data); mx_rwtype input 3 (RISC-V funct3 size/sign).
REQ-004 mx_gnt output 1 (command accepted pulse); mx_rvalid output 1 (load data valid pulse); mx_rdata output 32 (load data); mx_err output 1 (misaligned-access pulse).
REQ-005 Memory side: W_en output 1; R_en output 1; ram_addr output 32; RW_type output 3; WD output 32 (write data); RD input 32 (read data, combinational from ram_addr).

Function
REQ-006 SHALL implement FSM states IDLE, ISSUE and DONE: IDLE->ISSUE when any mx_req=1; ISSUE->DONE always; DONE->IDLE always.
REQ-007 In IDLE, on a cycle with a request, SHALL select a winner, latch its we/addr/wdata/rwtype and record its id at the clock edge.
REQ-008 Winner's mx_gnt SHALL be 1 for exactly the ISSUE cycle; all other gnt outputs 0.
REQ-009 Requesters SHALL hold req and command stable until gnt and deassert req the cycle after gnt; the arbiter SHALL ignore mx_req in ISSUE and DONE.
REQ-010 In ISSUE, for an aligned access: ram_addr, RW_type and WD driven from the latch; W_en=we and R_en=!we for that single cycle only.
REQ-011 Alignment: rwtype[1:0]=00 always aligned; 01 requires addr[0]=0; 10 requires addr[1:0]=00; 11 is treated as misaligned.
REQ-012 For a misaligned access in ISSUE: W_en=R_en=0 (no memory access); in DONE, winner's mx_err=1 for one cycle and mx_rvalid=0.
REQ-013 For an aligned load: RD SHALL be captured at the end of ISSUE; in DONE, winner's mx_rvalid=1 with mx_rdata=captured RD.
REQ-014 mx_rdata SHALL hold its last value when rvalid=0; mx_rvalid SHALL stay 0 for stores.
REQ-015 Outside ISSUE, W_en=R_en=0; ram_addr, RW_type and WD hold their last values.
REQ-016 Access latency: req seen in IDLE at cycle N gives gnt in N+1 and rvalid/err in N+2; next acceptance no earlier than N+3, so peak throughput is one access per 3 cycles.
REQ-017 When only one port requests, that port SHALL win regardless of arbitration policy.

Reset
REQ-018 rst=1 at a clock edge in any state SHALL force state to IDLE and clear every output to 0: gnt, rvalid, err, W_en, R_en, ram_addr, RW_type, WD and rdata.
REQ-019 Reset SHALL set the round-robin pointer to "port 1 served last", so port 0 wins the first contention.
REQ-020 Reset asserted during ISSUE SHALL abort the access; no rvalid or err pulse SHALL follow.

Configuration
REQ-021 With macro DMEM_ARB_RR_EN defined: on simultaneous requests, the port not served most recently wins; the pointer updates on every acceptance.
REQ-022 Without DMEM_ARB_RR_EN: fixed priority, port 0 always wins contention; no pointer register is synthesized.

Verification
REQ-023 Single load: mem[0x10]=0xDEADBEEF, m0 LW addr 0x10 -> m0_gnt at N+1 with R_en=1, ram_addr=0x10; m0_rvalid at N+2 with m0_rdata=0xDEADBEEF.
REQ-024 Store: m1 SW addr 0x20, wdata 0x12345678 -> W_en=1 only at N+1 with WD=0x12345678; no rvalid; a subsequent m0 LW 0x20 returns 0x12345678.
REQ-025 Contention, RR enabled: both ports request continuously for 4 accesses -> grant order 0,1,0,1; without the macro -> 0,0,0,0.
REQ-026 Misalignment: m0 LH addr 0x13 -> m0_gnt=1 with W_en=R_en=0, then m0_err=1 for one cycle; m0 LB addr 0x13 -> normal read.
REQ-027 Reset mid-op: assert rst during ISSUE of an m1 load -> next cycle all outputs 0, state IDLE, no rvalid; after release, m0 wins the first contention.
